// File: rtl/io_keysw_responder_if.sv
// Data-memory bus between the CPU load/store path and the key/switch responder.
// The CPU drives address, store data and strobes; the device returns read data and a select.
interface io_keysw_responder_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] din;
  logic             we;
  logic             re;
  logic [DBITS-1:0] dout;
  logic             sel;

  modport master (output addr, output din, output we, output re, input dout, input sel);
  modport slave  (input addr, input din, input we, input re, output dout, output sel);
endinterface

// File: rtl/io_keysw_responder.sv
// Memory-mapped KEY/SW responder: per-bank 2-flop sync, debounce, READY/OVR/IE status, IRQ.
// One bank module handles either input group; the top decodes the four registers.
module io_keysw_bank #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 500000,
  parameter int CNTBITS  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  input  logic             rd_data,
  input  logic             wr_ctrl,
  input  logic             ovr_keep,
  input  logic             ie_in,
  output logic [WIDTH-1:0] deb,
  output logic             ready,
  output logic             ovr,
  output logic             ie
);
  logic [WIDTH-1:0]   sync1_r, sync2_r, cand_r, deb_r;
  logic [CNTBITS-1:0] cnt_r;
  logic               ready_r, ovr_r, ie_r;
  logic [WIDTH-1:0]   cand_s, deb_s;
  logic [CNTBITS-1:0] cnt_s;
  logic               event_s, ready_s, ovr_s, ie_s;

  // Debounce next state: a new level must stay put for DEBOUNCE cycles before it is accepted.
  always_comb begin
    cand_s  = cand_r;
    deb_s   = deb_r;
    cnt_s   = cnt_r;
    event_s = 1'b0;
    if (sync2_r != cand_r) begin
      cand_s = sync2_r;
      cnt_s  = {CNTBITS{1'b0}};
    end else if ((sync2_r != deb_r) && (cnt_r == CNTBITS'(DEBOUNCE - 1))) begin
      deb_s   = cand_r;
      cnt_s   = {CNTBITS{1'b0}};
      event_s = 1'b1;
    end else if (sync2_r != deb_r) begin
      cnt_s = cnt_r + CNTBITS'(1);
    end else begin
      cnt_s = {CNTBITS{1'b0}};
    end
  end

  // Status next state: a change event outranks a same-cycle read, and a set outranks a clear.
  always_comb begin
    ready_s = ready_r;
    ovr_s   = ovr_r;
    ie_s    = ie_r;
    if (event_s) begin
      ready_s = 1'b1;
    end else if (rd_data) begin
      ready_s = 1'b0;
    end else begin
      ready_s = ready_r;
    end
    if (event_s && ready_r && !rd_data) begin
      ovr_s = 1'b1;
    end else if (wr_ctrl && !ovr_keep) begin
      ovr_s = 1'b0;
    end else begin
      ovr_s = ovr_r;
    end
    if (wr_ctrl) begin
      ie_s = ie_in;
    end else begin
      ie_s = ie_r;
    end
  end

  // Bank state registers, including the two-flop synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      cand_r  <= {WIDTH{1'b0}};
      deb_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNTBITS{1'b0}};
      ready_r <= 1'b0;
      ovr_r   <= 1'b0;
      ie_r    <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      cand_r  <= cand_s;
      deb_r   <= deb_s;
      cnt_r   <= cnt_s;
      ready_r <= ready_s;
      ovr_r   <= ovr_s;
      ie_r    <= ie_s;
    end
  end

  assign deb   = deb_r;
  assign ready = ready_r;
  assign ovr   = ovr_r;
  assign ie    = ie_r;
endmodule

module io_keysw_responder #(
  parameter int              DBITS      = 16,
  parameter int              DEBOUNCE   = 500000,
  parameter int              CNTBITS    = 20,
  parameter logic [DBITS-1:0] ADDR_KDATA = 16'hFFF0,
  parameter logic [DBITS-1:0] ADDR_SDATA = 16'hFFF2,
  parameter logic [DBITS-1:0] ADDR_KCTRL = 16'hFFF4,
  parameter logic [DBITS-1:0] ADDR_SCTRL = 16'hFFF6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            key,
  input  logic [9:0]            sw,
  io_keysw_responder_if.slave   bus,
  output logic                  irq
);
  logic [3:0] kdeb_s;
  logic [9:0] sdeb_s;
  logic       kready_s, kovr_s, kie_s, sready_s, sovr_s, sie_s;
  logic       unused_din_s;

  io_keysw_bank #(.WIDTH(4), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)) u_key (
    .clk      (clk),
    .reset    (reset),
    .raw      (key),
    .rd_data  (bus.re && (bus.addr == ADDR_KDATA)),
    .wr_ctrl  (bus.we && (bus.addr == ADDR_KCTRL)),
    .ovr_keep (bus.din[1]),
    .ie_in    (bus.din[4]),
    .deb      (kdeb_s),
    .ready    (kready_s),
    .ovr      (kovr_s),
    .ie       (kie_s)
  );

  io_keysw_bank #(.WIDTH(10), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)) u_sw (
    .clk      (clk),
    .reset    (reset),
    .raw      (sw),
    .rd_data  (bus.re && (bus.addr == ADDR_SDATA)),
    .wr_ctrl  (bus.we && (bus.addr == ADDR_SCTRL)),
    .ovr_keep (bus.din[1]),
    .ie_in    (bus.din[4]),
    .deb      (sdeb_s),
    .ready    (sready_s),
    .ovr      (sovr_s),
    .ie       (sie_s)
  );

  // Combinational read mux; unmapped addresses return a recognisable marker.
  always_comb begin
    bus.dout = DBITS'(16'hDEAD);
    bus.sel  = 1'b1;
    case (bus.addr)
      ADDR_KDATA: bus.dout = {{(DBITS-4){1'b0}}, kdeb_s};
      ADDR_SDATA: bus.dout = {{(DBITS-10){1'b0}}, sdeb_s};
      ADDR_KCTRL: bus.dout = {{(DBITS-5){1'b0}}, kie_s, 2'b00, kovr_s, kready_s};
      ADDR_SCTRL: bus.dout = {{(DBITS-5){1'b0}}, sie_s, 2'b00, sovr_s, sready_s};
      default: begin
        bus.dout = DBITS'(16'hDEAD);
        bus.sel  = 1'b0;
      end
    endcase
  end

  assign irq          = (kready_s & kie_s) | (sready_s & sie_s);
  assign unused_din_s = ^{bus.din[DBITS-1:5], bus.din[3:2], bus.din[0]};
endmodule

// File: tb/tb_io_keysw_responder.sv
// Directed, table-driven bench for io_keysw_responder with DEBOUNCE=4.
// Each row is driven after a falling edge and its outputs compared before the next rising edge.
module tb_io_keysw_responder;
  localparam logic [15:0] KD = 16'hFFF0;
  localparam logic [15:0] SD = 16'hFFF2;
  localparam logic [15:0] KC = 16'hFFF4;
  localparam logic [15:0] SC = 16'hFFF6;

  typedef struct {
    logic        rst;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [15:0] addr;
    logic [15:0] din;
    logic        we;
    logic        re;
    int          rep;
    logic [15:0] exp_dout;
    logic        exp_sel;
    logic        exp_irq;
    logic        chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic [9:0] sw;
  logic       irq;
  int         errors = 0;
  int         checks = 0;
  vec_t       vecs[$];

  io_keysw_responder_if #(.DBITS(16)) bus_if ();

  io_keysw_responder #(.DBITS(16), .DEBOUNCE(4), .CNTBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .sw    (sw),
    .bus   (bus_if),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [3:0] k, input logic [9:0] s,
                     input logic [15:0] a, input logic [15:0] d, input logic w,
                     input logic r, input int n, input logic [15:0] ed,
                     input logic es, input logic ei, input logic c);
    vec_t v;
    v = '{rst, k, s, a, d, w, r, n, ed, es, ei, c};
    vecs.push_back(v);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; key = 4'hF; sw = 10'h000;
    bus_if.addr = KC; bus_if.din = 16'h0000; bus_if.we = 1'b0; bus_if.re = 1'b0;

    // rst key sw addr din we re rep exp_dout sel irq chk
    add(1'b1, 4'hF, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4'hF, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 7, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h000, KD, 16'h0000, 1'b0, 1'b0, 1, 16'h000F, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h000, KD, 16'h0000, 1'b0, 1'b1, 1, 16'h000F, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    // switch glitch of 3 cycles, then a clean hold of 10'h155
    add(1'b0, 4'hF, 10'h001, SC, 16'h0000, 1'b0, 1'b0, 3, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h000, SC, 16'h0000, 1'b0, 1'b0, 7, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h000, SD, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h155, SC, 16'h0000, 1'b0, 1'b0, 7, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h155, SD, 16'h0000, 1'b0, 1'b0, 1, 16'h0155, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hF, 10'h155, SC, 16'h0000, 1'b0, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
    // two key changes without a read -> overrun, then OVR clear / keep writes
    add(1'b0, 4'h0, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 7, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h0, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 7, 16'h0001, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0003, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KD, 16'h0000, 1'b0, 1'b0, 1, 16'h0005, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0000, 1'b1, 1'b0, 1, 16'h0003, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0002, 1'b1, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
    // interrupt enable and clearing by a data read
    add(1'b0, 4'h5, 10'h155, KC, 16'h0010, 1'b1, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0011, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h5, 10'h155, KD, 16'h0000, 1'b0, 1'b1, 1, 16'h0005, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h5, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0010, 1'b1, 1'b0, 1'b1);
    // change event on the same edge as a KDATA read
    add(1'b0, 4'hA, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 6, 16'h0010, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hA, 10'h155, KD, 16'h0000, 1'b0, 1'b1, 1, 16'h0005, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'hA, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0011, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'hA, 10'h155, KD, 16'h0000, 1'b0, 1'b0, 1, 16'h000A, 1'b1, 1'b1, 1'b1);
    // unmapped and data-register accesses leave state alone
    add(1'b0, 4'hA, 10'h155, 16'h0100, 16'hFFFF, 1'b1, 1'b1, 1, 16'hDEAD, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'hA, 10'h155, 16'hFFF8, 16'hFFFF, 1'b1, 1'b1, 1, 16'hDEAD, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'hA, 10'h155, KD, 16'h1234, 1'b1, 1'b0, 1, 16'h000A, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'hA, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0011, 1'b1, 1'b1, 1'b1);
    // overrun kept by DIN[1]=1, cleared by DIN[1]=0
    add(1'b0, 4'h3, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 7, 16'h0011, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h3, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0013, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h3, 10'h155, KC, 16'h0012, 1'b1, 1'b0, 1, 16'h0013, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h3, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0013, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h3, 10'h155, KC, 16'h0010, 1'b1, 1'b0, 1, 16'h0013, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h3, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0011, 1'b1, 1'b1, 1'b1);
    // reset in the middle of a debounce
    add(1'b0, 4'h0, 10'h155, KC, 16'h0000, 1'b0, 1'b0, 4, 16'h0011, 1'b1, 1'b1, 1'b1);
    add(1'b1, 4'h0, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0011, 1'b1, 1'b1, 1'b1);
    add(1'b1, 4'h0, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b1, 4'h0, 10'h000, SC, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h0, 10'h000, KC, 16'h0000, 1'b0, 1'b0, 10, 16'h0000, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'h0, 10'h000, KD, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        @(negedge clk);
        reset = vecs[i].rst; key = vecs[i].key; sw = vecs[i].sw;
        bus_if.addr = vecs[i].addr; bus_if.din = vecs[i].din;
        bus_if.we = vecs[i].we; bus_if.re = vecs[i].re;
        #1;
        if (vecs[i].chk) begin
          check16($sformatf("row%0d.%0d dout", i, r), bus_if.dout, vecs[i].exp_dout);
          check16($sformatf("row%0d.%0d sel", i, r), {15'd0, bus_if.sel}, {15'd0, vecs[i].exp_sel});
          check16($sformatf("row%0d.%0d irq", i, r), {15'd0, irq}, {15'd0, vecs[i].exp_irq});
        end
      end
    end

    // Hand sequence: measure KREADY latency for a clean key change, then clear it by reading.
    @(negedge clk);
    key = 4'h6; bus_if.addr = KC; bus_if.we = 1'b0; bus_if.re = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_if.dout[0] && n < 20);
    check16("ready_latency", 16'(n), 16'd7);
    @(negedge clk);
    bus_if.addr = KD; bus_if.re = 1'b1;
    #1;
    check16("kdata_after_latency", bus_if.dout, 16'h0006);
    @(negedge clk);
    bus_if.addr = KC; bus_if.re = 1'b0;
    #1;
    check16("kctrl_after_read", bus_if.dout, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
